// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the Blink CPU-side bus initiator:
//   - tstate_e       : Z80 T-state sequence used by z80_bus_master
//   - CLKDIV_DEFAULT : mck cycles per T-state, matching the Blink's Z80 divider
//   - PORT_*         : Blink I/O register addresses (low address byte)
//   - in_strobe_phase: T-states during which the bus strobe and crd_n are active
// -----------------------------------------------------------------------------
package blink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_DONE = 3'd5
  } tstate_e;

  localparam int CLKDIV_DEFAULT = 3;

  // Screen / bank-switch registers
  localparam logic [7:0] PORT_PB0  = 8'h70;
  localparam logic [7:0] PORT_PB1  = 8'h71;
  localparam logic [7:0] PORT_PB2  = 8'h72;
  localparam logic [7:0] PORT_PB3  = 8'h73;
  localparam logic [7:0] PORT_SBR  = 8'h74;
  // Control, interrupt and keyboard registers
  localparam logic [7:0] PORT_COM  = 8'hB0;
  localparam logic [7:0] PORT_INT  = 8'hB1;
  localparam logic [7:0] PORT_KBD  = 8'hB2;
  localparam logic [7:0] PORT_EPR  = 8'hB3;
  localparam logic [7:0] PORT_TACK = 8'hB4;
  localparam logic [7:0] PORT_TMK  = 8'hB5;
  localparam logic [7:0] PORT_ACK  = 8'hB6;
  // Segment registers on write; RTC TIM0-TIM4 on read
  localparam logic [7:0] PORT_SR0  = 8'hD0;
  localparam logic [7:0] PORT_SR1  = 8'hD1;
  localparam logic [7:0] PORT_SR2  = 8'hD2;
  localparam logic [7:0] PORT_SR3  = 8'hD3;
  localparam logic [7:0] PORT_TIM4 = 8'hD4;

  // mrq_n/ior_n and crd_n are active from T2 entry until T3 ends.
  function automatic logic in_strobe_phase(tstate_e s);
    return (s == ST_T2) || (s == ST_TW) || (s == ST_T3);
  endfunction

endpackage

// File: rtl/busm_tick.sv
// -----------------------------------------------------------------------------
// busm_tick
// T-state prescaler: counts mck cycles within a T-state and pulses tick_o on the
// last mck of each T-state. clr_i restarts the count so a T-state sequence
// started on accept has deterministic length.
// Ports:
//   mck    : master clock
//   rin    : synchronous active-high reset
//   clr_i  : restart count (next cycle is the first of a T-state)
//   tick_o : high on the last mck cycle of the current T-state
// -----------------------------------------------------------------------------
module busm_tick #(
  parameter int CLKDIV = 3
) (
  input  logic mck,
  input  logic rin,
  input  logic clr_i,
  output logic tick_o
);

  // One bit minimum so CLKDIV=1 still elaborates; the count then stays at 0.
  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge mck) begin
    if (rin) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/z80_bus_master.sv
// -----------------------------------------------------------------------------
// z80_bus_master
// Z80-timed bus initiator for the Blink CPU-side bus. Accepts single-beat
// memory/I/O read/write commands and runs T1-T2-[TW]-T3 cycles, then returns a
// one-cycle response carrying read data.
// Ports:
//   mck, rin                  : master clock, synchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_wr, cmd_io            : 1=write/0=read, 1=I/O/0=memory
//   cmd_addr, cmd_wdata       : 16-bit address, write data
//   rsp_valid, rsp_rdata      : completion pulse and read data (0x00 on writes)
//   ca, bus_do, bus_di        : address bus, data to Blink, data from Blink
//   mrq_n, ior_n, crd_n, cm1_n: bus strobes (cm1_n is always 1)
//   wait_n                    : only with BUSM_WAIT_EN; 0 stretches the cycle
// Configuration macro: BUSM_WAIT_EN adds the wait_n input. I/O cycles always
// get one TW; wait_n=0 at the end of T2 or a TW inserts a further TW.
// -----------------------------------------------------------------------------
module z80_bus_master
  import blink_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEFAULT  // mck per T-state, >= 1
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic        cmd_io,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
`ifdef BUSM_WAIT_EN
  input  logic        wait_n,
`endif
  output logic [15:0] ca,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di,
  output logic        mrq_n,
  output logic        ior_n,
  output logic        crd_n,
  output logic        cm1_n
);

  tstate_e     state_q, state_d;
  logic [15:0] ca_q, ca_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        io_q, io_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  bus_do_q, bus_do_d;
  logic        rsp_q, rsp_d;
  logic        mrq_q, mrq_d;
  logic        ior_q, ior_d;
  logic        crd_q, crd_d;
  logic        accept;
  logic        tick;
  logic        wait_req;

`ifdef BUSM_WAIT_EN
  assign wait_req = ~wait_n;
`else
  assign wait_req = 1'b0;
`endif

  busm_tick #(.CLKDIV(CLKDIV)) u_tick (
    .mck    (mck),
    .rin    (rin),
    .clr_i  (accept),
    .tick_o (tick)
  );

  assign cmd_ready = (state_q == ST_IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ca_d    = ca_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    io_d    = io_q;
    rdata_d = rdata_q;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          ca_d    = cmd_addr;
          wdata_d = cmd_wdata;
          wr_d    = cmd_wr;
          io_d    = cmd_io;
          state_d = ST_T1;
        end
      end
      ST_T1: if (tick) state_d = ST_T2;
      ST_T2: if (tick) state_d = (io_q || wait_req) ? ST_TW : ST_T3;
      ST_TW: if (tick) state_d = wait_req ? ST_TW : ST_T3;
      ST_T3: begin
        if (tick) begin
          rdata_d = wr_q ? 8'h00 : bus_di;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are decoded from the next state and registered, so strobes
    // and crd_n change on the same edge as the state and never glitch. A read
    // therefore can never show a strobe low while crd_n is still high.
    mrq_d    = ~(in_strobe_phase(state_d) && !io_d);
    ior_d    = ~(in_strobe_phase(state_d) &&  io_d);
    crd_d    = ~(in_strobe_phase(state_d) && !wr_d);
    bus_do_d = ((state_d != ST_IDLE) && (state_d != ST_DONE) && wr_d) ? wdata_d : 8'h00;
    rsp_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      state_q  <= ST_IDLE;
      ca_q     <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
      rdata_q  <= '0;
      bus_do_q <= '0;
      rsp_q    <= 1'b0;
      mrq_q    <= 1'b1;
      ior_q    <= 1'b1;
      crd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ca_q     <= ca_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      io_q     <= io_d;
      rdata_q  <= rdata_d;
      bus_do_q <= bus_do_d;
      rsp_q    <= rsp_d;
      mrq_q    <= mrq_d;
      ior_q    <= ior_d;
      crd_q    <= crd_d;
    end
  end

  assign ca        = ca_q;
  assign bus_do    = bus_do_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign mrq_n     = mrq_q;
  assign ior_n     = ior_q;
  assign crd_n     = crd_q;
  assign cm1_n     = 1'b1;  // no opcode fetch or refresh cycles are issued

endmodule

// File: tb/tb_z80_bus_master.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_master
// Directed and random commands against z80_bus_master (default build,
// CLKDIV=3). Expected bus waveforms come from T-state arithmetic: a cycle of
// N T-states holds its strobe low for mck (CLKDIV, N*CLKDIV] after accept and
// responds at N*CLKDIV+1. Read data comes from a small memory/I/O model.
// -----------------------------------------------------------------------------
module tb_z80_bus_master;
  import blink_pkg::*;

  localparam int CLKDIV = 3;

  typedef struct {
    bit          wr;
    bit          io;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  logic        mck = 1'b0;
  logic        rin = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic        cmd_io = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  bus_di = '0;
  logic        cmd_ready, rsp_valid, mrq_n, ior_n, crd_n, cm1_n;
  logic [7:0]  rsp_rdata, bus_do;
  logic [15:0] ca;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mem_model [logic [15:0]];
  logic [7:0] io_model  [logic [15:0]];

  z80_bus_master #(.CLKDIV(CLKDIV)) dut (
    .mck       (mck),
    .rin       (rin),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_io    (cmd_io),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ca        (ca),
    .bus_do    (bus_do),
    .bus_di    (bus_di),
    .mrq_n     (mrq_n),
    .ior_n     (ior_n),
    .crd_n     (crd_n),
    .cm1_n     (cm1_n)
  );

  always #5 mck = ~mck;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_read(input bit io, input logic [15:0] a);
    logic [7:0] v;
    if (io) begin
      if (!io_model.exists(a)) io_model[a] = 8'($urandom);
      v = io_model[a];
    end else begin
      if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
      v = mem_model[a];
    end
    return v;
  endfunction

  task automatic present(input cmd_t c);
    cmd_wr    = c.wr;
    cmd_io    = c.io;
    cmd_addr  = c.addr;
    cmd_wdata = c.data;
    cmd_valid = 1'b1;
  endtask

  // Runs one command from accept to the IDLE cycle after its response.
  // With chain set, the next command is presented (cmd_valid kept high)
  // right after accept, and must be accepted straight out of that IDLE cycle.
  task automatic run_cmd(input cmd_t c, input bit chain, input cmd_t nxt, input string name);
    int         nt, last, waited;
    bit         strobe;
    logic [7:0] rd, drive_val;
    nt   = c.io ? 4 : 3;
    last = nt * CLKDIV + 1;
    if (c.wr) begin
      if (c.io) io_model[c.addr] = c.data;
      else      mem_model[c.addr] = c.data;
      rd        = 8'h00;
      drive_val = 8'($urandom);
    end else begin
      rd        = model_read(c.io, c.addr);
      drive_val = rd;
    end
    present(c);
    bus_di = ~drive_val;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge mck);
      waited++;
    end
    if (!cmd_ready) begin
      check({name, " accept_timeout"}, 16'(cmd_ready), 16'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (chain) check({name, " chained_ready_wait"}, 16'(waited), 16'd0);
    @(posedge mck);  // accept edge
    for (int k = 1; k <= last; k++) begin
      @(negedge mck);
      if (k == 1) begin
        if (chain) present(nxt);
        else cmd_valid = 1'b0;
      end
      strobe = (k > CLKDIV) && (k <= nt * CLKDIV);
      check($sformatf("%s k%0d ca", name, k), ca, c.addr);
      check($sformatf("%s k%0d mrq_n", name, k), 16'(mrq_n), 16'(!(strobe && !c.io)));
      check($sformatf("%s k%0d ior_n", name, k), 16'(ior_n), 16'(!(strobe && c.io)));
      check($sformatf("%s k%0d crd_n", name, k), 16'(crd_n), 16'(!(strobe && !c.wr)));
      check($sformatf("%s k%0d cm1_n", name, k), 16'(cm1_n), 16'd1);
      check($sformatf("%s k%0d bus_do", name, k), 16'(bus_do),
            16'((c.wr && k < last) ? c.data : 8'h00));
      check($sformatf("%s k%0d rsp_valid", name, k), 16'(rsp_valid), 16'(k == last));
      check($sformatf("%s k%0d cmd_ready", name, k), 16'(cmd_ready), 16'd0);
      if (k == last) check({name, " rsp_rdata"}, 16'(rsp_rdata), 16'(rd));
      // Only the last mck of T3 carries the real data.
      bus_di = (k == nt * CLKDIV) ? drive_val : ~drive_val;
    end
    @(negedge mck);
    check({name, " idle cmd_ready"}, 16'(cmd_ready), 16'd1);
    check({name, " idle rsp_valid"}, 16'(rsp_valid), 16'd0);
    check({name, " idle strobes"}, {13'd0, mrq_n, ior_n, crd_n}, 16'h0007);
  endtask

  initial begin
    cmd_t c, c2, q[$];
    bit   saw_rsp;

    // Reset state
    repeat (3) @(posedge mck);
    @(negedge mck);
    check("reset cmd_ready", 16'(cmd_ready), 16'd1);
    check("reset rsp_valid", 16'(rsp_valid), 16'd0);
    check("reset rsp_rdata", 16'(rsp_rdata), 16'd0);
    check("reset ca", ca, 16'h0000);
    check("reset bus_do", 16'(bus_do), 16'd0);
    check("reset strobes", {12'd0, mrq_n, ior_n, crd_n, cm1_n}, 16'h000F);
    rin = 1'b0;
    @(negedge mck);

    // Directed commands
    c = '{wr: 1'b1, io: 1'b0, addr: 16'h4123, data: 8'hA5};
    run_cmd(c, 1'b0, c, "memwr_4123");
    c = '{wr: 1'b1, io: 1'b1, addr: {8'h00, PORT_SR1}, data: 8'h21};
    run_cmd(c, 1'b0, c, "iowr_sr1");
    c = '{wr: 1'b0, io: 1'b0, addr: 16'h4000, data: 8'h00};
    run_cmd(c, 1'b0, c, "memrd_4000");
    io_model[{8'hFE, PORT_KBD}] = 8'hF7;  // row 0, key bit 3 pressed
    c = '{wr: 1'b0, io: 1'b1, addr: {8'hFE, PORT_KBD}, data: 8'h00};
    run_cmd(c, 1'b0, c, "iord_kbd");
    c = '{wr: 1'b0, io: 1'b0, addr: 16'h4123, data: 8'h00};
    run_cmd(c, 1'b0, c, "memrd_4123");

    // Back-to-back with cmd_valid held high
    c  = '{wr: 1'b1, io: 1'b0, addr: 16'h8000, data: 8'h3C};
    c2 = '{wr: 1'b0, io: 1'b0, addr: 16'h8000, data: 8'h00};
    run_cmd(c, 1'b1, c2, "b2b_first");
    run_cmd(c2, 1'b0, c2, "b2b_second");

    // Reset during the TW of an I/O write
    c = '{wr: 1'b1, io: 1'b1, addr: {8'h00, PORT_COM}, data: 8'h5A};
    present(c);
    @(posedge mck);  // accept edge
    for (int k = 1; k <= 2 * CLKDIV + 2; k++) begin
      @(negedge mck);
      if (k == 1) cmd_valid = 1'b0;
    end
    check("abort pre ior_n", 16'(ior_n), 16'd0);
    rin = 1'b1;
    @(negedge mck);
    check("abort ior_n", 16'(ior_n), 16'd1);
    check("abort crd_n", 16'(crd_n), 16'd1);
    check("abort mrq_n", 16'(mrq_n), 16'd1);
    check("abort bus_do", 16'(bus_do), 16'd0);
    check("abort ca", ca, 16'h0000);
    check("abort rsp_valid", 16'(rsp_valid), 16'd0);
    @(negedge mck);
    rin = 1'b0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge mck);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("abort no rsp", 16'(saw_rsp), 16'd0);
    check("abort cmd_ready", 16'(cmd_ready), 16'd1);

    // Random commands, some chained
    for (int i = 0; i < 24; i++) begin
      c.wr   = 1'($urandom);
      c.io   = 1'($urandom);
      c.addr = c.io ? 16'($urandom) : (16'hC000 | 16'($urandom_range(0, 7)));
      c.data = 8'($urandom);
      q.push_back(c);
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i + 1 < q.size() && ($urandom_range(0, 1) == 1))
        run_cmd(q[i], 1'b1, q[i+1], $sformatf("rnd%0d", i));
      else
        run_cmd(q[i], 1'b0, q[i], $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
